// File: rtl/cond_unit.sv
// ARM condition evaluation: architectural NZCV register, condition decode and write/branch gating.
// Optional macro COND_UNIT_FLAG_BYPASS_EN adds fwd_valid/fwd_flags same-cycle flag forwarding.
module cond_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
`ifdef COND_UNIT_FLAG_BYPASS_EN
    input  logic             fwd_valid,
    input  logic [3:0]       fwd_flags,
`endif
    output logic [3:0]       flags,
    output logic             cond_ex,
    output logic             cond_ex_q,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0]       flags_q, flags_d;
    logic [3:0]       eval_flags;
    logic             cond_ex_q_q, cond_ex_q_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             n, z, c, v;

`ifdef COND_UNIT_FLAG_BYPASS_EN
    // An older in-flight instruction's flags win over the stale register.
    assign eval_flags = fwd_valid ? fwd_flags : flags_q;
`else
    assign eval_flags = flags_q;
`endif

    assign {n, z, c, v} = eval_flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign pc_src    = pcs & cond_ex;
    assign reg_write = reg_w & ~no_write & cond_ex;
    assign mem_write = mem_w & cond_ex;

    always_comb begin
        flags_d     = flags_q;
        cond_ex_q_d = cond_ex_q_q;
        squash_d    = squash_q;
        if (en) begin
            cond_ex_q_d = cond_ex;
            if (cond_ex) begin
                if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
                if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
            end else if (~&squash_q) begin
                squash_d = squash_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= 4'b0000;
            cond_ex_q_q <= 1'b0;
            squash_q    <= '0;
        end else begin
            flags_q     <= flags_d;
            cond_ex_q_q <= cond_ex_q_d;
            squash_q    <= squash_d;
        end
    end

    assign flags      = flags_q;
    assign cond_ex_q  = cond_ex_q_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: per-cycle model comparison plus directed literal checks.
// Covers COND_UNIT_FLAG_BYPASS_EN forwarding when that macro is defined.
module tb_cond_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  cond = 4'b0000;
    logic [3:0]  alu_flags = 4'b0000;
    logic [1:0]  flag_w = 2'b00;
    logic        pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
`ifdef COND_UNIT_FLAG_BYPASS_EN
    logic        fwd_valid = 1'b0;
    logic [3:0]  fwd_flags = 4'b0000;
`endif

    logic [3:0]  flags, flags_s;
    logic        cond_ex, cond_ex_q, pc_src, reg_write, mem_write;
    logic        cond_ex_s, cond_ex_q_s, pc_src_s, reg_write_s, mem_write_s;
    logic [15:0] squash_cnt;
    logic [1:0]  squash_cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk(clk), .reset_n(reset_n), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
`ifdef COND_UNIT_FLAG_BYPASS_EN
        .fwd_valid(fwd_valid), .fwd_flags(fwd_flags),
`endif
        .flags(flags), .cond_ex(cond_ex), .cond_ex_q(cond_ex_q), .pc_src(pc_src),
        .reg_write(reg_write), .mem_write(mem_write), .squash_cnt(squash_cnt)
    );

    // Narrow counter instance shares all inputs so saturation is reachable quickly.
    cond_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
`ifdef COND_UNIT_FLAG_BYPASS_EN
        .fwd_valid(fwd_valid), .fwd_flags(fwd_flags),
`endif
        .flags(flags_s), .cond_ex(cond_ex_s), .cond_ex_q(cond_ex_q_s), .pc_src(pc_src_s),
        .reg_write(reg_write_s), .mem_write(mem_write_s), .squash_cnt(squash_cnt_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition passes iff the base predicate of cond[3:1] holds, inverted when cond[0] is set.
    function automatic bit model_cond(input logic [3:0] cd, input logic [3:0] f);
        bit fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (cd[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: return cd[0] == 1'b0;
        endcase
        return cd[0] ? !base : base;
    endfunction

    logic [3:0] m_flags;
    bit         m_cq;
    int         m_cnt;

    function automatic logic [3:0] model_src();
`ifdef COND_UNIT_FLAG_BYPASS_EN
        if (fwd_valid) return fwd_flags;
`endif
        return m_flags;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_flags <= 4'b0000;
            m_cq    <= 1'b0;
            m_cnt   <= 0;
        end else if (en) begin
            if (model_cond(cond, model_src())) begin
                m_cq <= 1'b1;
                m_flags <= {flag_w[1] ? alu_flags[3:2] : m_flags[3:2],
                            flag_w[0] ? alu_flags[1:0] : m_flags[1:0]};
            end else begin
                m_cq  <= 1'b0;
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            bit ok;
            ok = model_cond(cond, model_src());
            chk("flags", flags, m_flags);
            chk("cond_ex", cond_ex, ok);
            chk("cond_ex_q", cond_ex_q, m_cq);
            chk("pc_src", pc_src, pcs && ok);
            chk("reg_write", reg_write, reg_w && !no_write && ok);
            chk("mem_write", mem_write, mem_w && ok);
            chk("squash_cnt", squash_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
            chk("squash_cnt_w2", squash_cnt_s, (m_cnt > 3) ? 3 : m_cnt);
        end
    end

    task automatic apply(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic r, input logic m, input logic nw,
                         input logic e);
        cond = c; alu_flags = af; flag_w = fw;
        pcs = p; reg_w = r; mem_w = m; no_write = nw; en = e;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        logic [3:0] pats [6];
        sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        pats = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h6, 4'h9};

        next_edge();
        next_edge();
        chk("rst_flags", flags, 4'b0000);
        chk("rst_cond_ex_q", cond_ex_q, 1'b0);
        chk("rst_squash", squash_cnt, 16'd0);
        reset_n = 1'b1;

        // AL register write
        apply(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("al_reg_write", reg_write, 1'b1);
        chk("al_cond_ex", cond_ex, 1'b1);
        next_edge();
        chk("al_squash", squash_cnt, 16'd0);

        // Set Z, then EQ passes and NE fails
        apply(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_edge();
        chk("z_flags", flags, 4'b0100);
        apply(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("eq_cond_ex", cond_ex, 1'b1);
        next_edge();
        apply(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ne_cond_ex", cond_ex, 1'b0);
        next_edge();

        // Independent halves
        apply(4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_edge();
        chk("nz_half", flags, 4'b1000);
        apply(4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_edge();
        chk("cv_half", flags, 4'b1011);
        apply(4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_edge();

        // N=1 V=0: LT passes, GE fails and must not touch flags
        apply(4'b1011, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lt_pc_src", pc_src, 1'b1);
        chk("lt_mem_write", mem_write, 1'b1);
        next_edge();
        apply(4'b1010, 4'b0111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ge_pc_src", pc_src, 1'b0);
        chk("ge_mem_write", mem_write, 1'b0);
        next_edge();
        chk("ge_flags_held", flags, 4'b1000);
        chk("ge_squash", squash_cnt, 16'd1);

        // Reserved condition saturates the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            apply(4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            next_edge();
            chk("sat_w2", squash_cnt_s, sat_exp[i]);
        end
        chk("sat_w16", squash_cnt, 16'd6);
        chk("nv_flags_held", flags, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            apply(4'b1111, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            next_edge();
        end
        chk("en0_hold", squash_cnt, 16'd6);

        // Mid-cycle asynchronous reset
        apply(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_edge();
        chk("pre_rst_cq", cond_ex_q, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_squash", squash_cnt, 16'd0);
        chk("async_flags", flags, 4'b0000);
        chk("async_cq", cond_ex_q, 1'b0);
        #1 reset_n = 1'b1;
        apply(4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_edge();
        chk("post_rst_squash", squash_cnt, 16'd1);

`ifdef COND_UNIT_FLAG_BYPASS_EN
        apply(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fwd_valid = 1'b1;
        fwd_flags = 4'b0100;
        @(negedge clk);
        chk("fwd_cond_ex", cond_ex, 1'b1);
        next_edge();
        fwd_valid = 1'b0;
        @(negedge clk);
        chk("nofwd_cond_ex", cond_ex, 1'b0);
        next_edge();
`endif

        // Directed sweep over all conditions and flag patterns
        for (int i = 0; i < 48; i++) begin
            apply(4'(i % 16), pats[i % 6], 2'(i % 4), 1'(i % 2), 1'((i / 2) % 2),
                  1'((i / 4) % 2), 1'(i % 5 == 0), 1'(i % 7 != 3));
            next_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
